rle_enc_param: RTL and testbench

- Parametrised second-generation run-length encoder. Reads a byte stream from the shared single-port DPSRAM (port A), and writes (count, symbol) pairs back to the same memory.
- Adds over the first generation:
  - configurable maximum run length, with long runs split;
  - configurable address width;
  - packed two-pairs-per-word output;
  - a defined done/rle_size completion handshake.
- Sits between the frame controller (which drives start and the addresses and sizes) and the DPSRAM.

---
 rtl/rle_enc_param.sv | 232 +++++++++++++++++++++++
 tb/tb_rle_enc_param.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_enc_param.sv
// Run-length encoder: reads bytes from the DPSRAM on port A and writes packed
// (count, symbol) pairs back, two pairs per 32-bit word, splitting runs at MAX_RUN.
module rle_enc_param #(
  parameter int ADDR_W  = 16,
  parameter int MAX_RUN = 255
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       message_size,
  input  logic [31:0]       rle_addr,
  output logic [31:0]       rle_size,
  output logic              done,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_RUN);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, SCAN, WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]       size_q, size_d;
  logic [31:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        run_sym_q, run_sym_d;
  logic [7:0]        run_cnt_q, run_cnt_d;
  logic [31:0]       buf_q, buf_d;
  logic [1:0]        buf_n_q, buf_n_d;
  logic              pend_q, pend_d;
  logic              fin_q, fin_d;
  logic              done_q, done_d;
  logic [31:0]       rle_size_q, rle_size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       din_q, din_d;

  logic [7:0]        cur_byte;
  logic              is_last;

  // Only the word-aligned low ADDR_W bits of the byte addresses are used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{message_addr, rle_addr};

  assign port_A_clk     = clk;
  assign port_A_addr    = addr_q;
  assign port_A_we      = we_q;
  assign port_A_data_in = din_q;
  assign done           = done_q;
  assign rle_size       = rle_size_q;

  function automatic logic [31:0] put_pair(input logic [31:0] b, input logic slot,
                                           input logic [7:0] cnt, input logic [7:0] sym);
    logic [31:0] r;
    r = b;
    if (slot) r[31:16] = {sym, cnt};
    else      r[15:0]  = {sym, cnt};
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    size_d     = size_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    idx_d      = idx_q;
    run_sym_d  = run_sym_q;
    run_cnt_d  = run_cnt_q;
    buf_d      = buf_q;
    buf_n_d    = buf_n_q;
    pend_d     = pend_q;
    fin_d      = fin_q;
    done_d     = done_q;
    rle_size_d = rle_size_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    din_d      = din_q;
    cur_byte   = word_q[{idx_q, 3'b000} +: 8];
    is_last    = (byte_cnt_q + 32'd1) == size_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          rd_ptr_d   = {message_addr[ADDR_W-1:2], 2'b00};
          wr_ptr_d   = {rle_addr[ADDR_W-1:2], 2'b00};
          size_d     = message_size;
          byte_cnt_d = 32'd0;
          idx_d      = 2'd0;
          run_sym_d  = 8'd0;
          run_cnt_d  = 8'd0;
          buf_d      = 32'd0;
          buf_n_d    = 2'd0;
          pend_d     = 1'b0;
          fin_d      = 1'b0;
          rle_size_d = 32'd0;
          if (message_size == 32'd0) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            done_d  = 1'b0;
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        word_d   = port_A_data_out;
        rd_ptr_d = rd_ptr_q + ADDR_W'(4);
        idx_d    = 2'd0;
        state_d  = SCAN;
      end
      SCAN: begin
        byte_cnt_d = byte_cnt_q + 32'd1;
        idx_d      = idx_q + 2'd1;
        if (run_cnt_q == 8'd0) begin
          run_sym_d = cur_byte;
          run_cnt_d = 8'd1;
        end else if (cur_byte == run_sym_q && run_cnt_q < MAX_CNT) begin
          run_cnt_d = run_cnt_q + 8'd1;
        end else begin
          buf_d      = put_pair(buf_d, buf_n_d[0], run_cnt_q, run_sym_q);
          buf_n_d    = buf_n_d + 2'd1;
          rle_size_d = rle_size_d + 32'd2;
          run_sym_d  = cur_byte;
          run_cnt_d  = 8'd1;
        end
        if (is_last) begin
          // A full buffer defers the closing pair to a second WR visit.
          if (buf_n_d == 2'd2) begin
            pend_d = 1'b1;
          end else begin
            buf_d      = put_pair(buf_d, buf_n_d[0], run_cnt_d, run_sym_d);
            buf_n_d    = buf_n_d + 2'd1;
            rle_size_d = rle_size_d + 32'd2;
            fin_d      = 1'b1;
          end
          state_d = WR;
        end else if (buf_n_d == 2'd2) begin
          state_d = WR;
        end else if (idx_q == 2'd3) begin
          state_d = RD_REQ;
        end else begin
          state_d = SCAN;
        end
      end
      WR: begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(4);
        buf_d    = 32'd0;
        buf_n_d  = 2'd0;
        if (pend_q) begin
          buf_d      = put_pair(32'd0, 1'b0, run_cnt_q, run_sym_q);
          buf_n_d    = 2'd1;
          rle_size_d = rle_size_q + 32'd2;
          pend_d     = 1'b0;
          fin_d      = 1'b1;
          state_d    = WR;
        end else if (fin_q) begin
          fin_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (idx_q == 2'd0) begin
          state_d = RD_REQ;
        end else begin
          state_d = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Port A outputs are registered so they line up with the state being entered.
    if (state_d == RD_REQ) begin
      addr_d = rd_ptr_d;
    end
    if (state_d == WR) begin
      we_d   = 1'b1;
      addr_d = wr_ptr_d;
      din_d  = buf_d;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      size_q     <= 32'd0;
      byte_cnt_q <= 32'd0;
      word_q     <= 32'd0;
      idx_q      <= 2'd0;
      run_sym_q  <= 8'd0;
      run_cnt_q  <= 8'd0;
      buf_q      <= 32'd0;
      buf_n_q    <= 2'd0;
      pend_q     <= 1'b0;
      fin_q      <= 1'b0;
      done_q     <= 1'b0;
      rle_size_q <= 32'd0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      din_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      size_q     <= size_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      run_sym_q  <= run_sym_d;
      run_cnt_q  <= run_cnt_d;
      buf_q      <= buf_d;
      buf_n_q    <= buf_n_d;
      pend_q     <= pend_d;
      fin_q      <= fin_d;
      done_q     <= done_d;
      rle_size_q <= rle_size_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      din_q      <= din_d;
    end
  end

endmodule

// File: tb/tb_rle_enc_param.sv
// Bench for rle_enc_param: two instances (MAX_RUN 255 and 4), each with its own
// synchronous-read memory model; expected writes are queued and checked as they occur.
module tb_rle_enc_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        nreset;
  logic [1:0]  start;
  logic [31:0] message_addr, message_size, rle_addr;
  logic [31:0] rle_size [2];
  logic [1:0]  done, pclk, pwe;
  logic [15:0] paddr [2];
  logic [31:0] pdin [2];
  logic [31:0] pdout [2];

  logic [1:0]  ld_we;
  logic [13:0] ld_idx;
  logic [31:0] ld_data;
  logic [31:0] mem [2][16384];

  logic [15:0] exp_addr [$];
  logic [31:0] exp_data [$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rle_enc_param #(.ADDR_W(16), .MAX_RUN(g == 0 ? 255 : 4)) dut (
      .clk             (clk),
      .nreset          (nreset),
      .start           (start[g]),
      .message_addr    (message_addr),
      .message_size    (message_size),
      .rle_addr        (rle_addr),
      .rle_size        (rle_size[g]),
      .done            (done[g]),
      .port_A_clk      (pclk[g]),
      .port_A_addr     (paddr[g]),
      .port_A_we       (pwe[g]),
      .port_A_data_in  (pdin[g]),
      .port_A_data_out (pdout[g])
    );
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (pwe[g]) mem[g][paddr[g][15:2]] <= pdin[g];
      else if (ld_we[g]) mem[g][ld_idx] <= ld_data;
      pdout[g] <= mem[g][paddr[g][15:2]];
    end
  end

  task automatic load(input int g, input logic [31:0] maddr, input logic [7:0] bytes[$]);
    int nw;
    logic [31:0] word;
    nw = (bytes.size() + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 4; k++)
        word[8*k +: 8] = (4*w + k < bytes.size()) ? bytes[4*w + k] : 8'hC3;
      @(negedge clk);
      ld_we[g] = 1'b1;
      ld_idx   = 14'(maddr[15:2] + 14'(w));
      ld_data  = word;
    end
    @(negedge clk);
    ld_we = 2'b00;
  endtask

  // Reference RLE: split runs at the instance's MAX_RUN, pack two pairs per word.
  task automatic expect_writes(input int g, input logic [31:0] raddr, input logic [7:0] bytes[$],
                               output logic [31:0] exp_size);
    int mr, cnt;
    logic [7:0] sym;
    logic [7:0] cq[$], sq[$];
    logic [31:0] word;
    mr = (g == 0) ? 255 : 4;
    cnt = 0;
    sym = 8'h00;
    for (int i = 0; i < bytes.size(); i++) begin
      if (i == 0) begin sym = bytes[i]; cnt = 1; end
      else if (bytes[i] == sym && cnt < mr) cnt++;
      else begin cq.push_back(8'(cnt)); sq.push_back(sym); sym = bytes[i]; cnt = 1; end
    end
    if (bytes.size() > 0) begin cq.push_back(8'(cnt)); sq.push_back(sym); end
    exp_size = 32'(2 * cq.size());
    for (int p = 0; p < cq.size(); p += 2) begin
      word = {16'h0000, sq[p], cq[p]};
      if (p + 1 < cq.size()) word[31:16] = {sq[p+1], cq[p+1]};
      exp_addr.push_back(16'({raddr[15:2], 2'b00} + 32'(2 * p)));
      exp_data.push_back(word);
    end
  endtask

  task automatic watch(input int g, input int budget, input bit until_done, input bit poke,
                       output bit got_done, output int nwr);
    logic [15:0] ea;
    logic [31:0] ed;
    got_done = 1'b0;
    nwr = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (pwe[g]) begin
        nwr++;
        checks++;
        if (exp_addr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write dut%0d addr=%h data=%h, required no write", g, paddr[g], pdin[g]);
        end else begin
          ea = exp_addr.pop_front();
          ed = exp_data.pop_front();
          if (paddr[g] !== ea || pdin[g] !== ed) begin
            errors++;
            $display("FAIL write dut%0d got addr=%h data=%h, required addr=%h data=%h",
                     g, paddr[g], pdin[g], ea, ed);
          end
        end
      end
      if (until_done && done[g]) begin
        got_done = 1'b1;
        break;
      end
      start[g] = poke && (c % 7 == 3);
    end
    start[g] = 1'b0;
  endtask

  task automatic run_case(input int g, input logic [31:0] maddr, input logic [31:0] raddr,
                          input logic [7:0] bytes[$], input bit poke, input string name);
    logic [31:0] esz;
    bit got;
    int nwr;
    load(g, maddr, bytes);
    expect_writes(g, raddr, bytes, esz);
    message_addr = maddr;
    message_size = 32'(bytes.size());
    rle_addr     = raddr;
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    watch(g, 8 * bytes.size() + 100, 1'b1, poke, got, nwr);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_done got done=%b, required 1 before timeout", name, done[g]);
    end
    checks++;
    if (rle_size[g] !== esz) begin
      errors++;
      $display("FAIL %s_rle_size got %0d, required %0d", name, rle_size[g], esz);
    end
    checks++;
    if (exp_addr.size() != 0) begin
      errors++;
      $display("FAIL %s_writes got %0d writes, required %0d more", name, nwr, exp_addr.size());
    end
    exp_addr.delete();
    exp_data.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (done[0] !== 1'b0 || rle_size[0] !== 32'd0 || pwe[0] !== 1'b0 ||
        paddr[0] !== 16'd0 || pdin[0] !== 32'd0) begin
      errors++;
      $display("FAIL %s got done=%b size=%h we=%b addr=%h din=%h, required all zero",
               name, done[0], rle_size[0], pwe[0], paddr[0], pdin[0]);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    checks++;
    if (done[1] !== 1'b0 || pwe[1] !== 1'b0 || rle_size[1] !== 32'd0) begin
      errors++;
      $display("FAIL reset_state_dut1 got done=%b we=%b size=%h, required 0", done[1], pwe[1], rle_size[1]);
    end
    checks++;
    if (pclk[0] !== clk) begin
      errors++;
      $display("FAIL port_clk_low got %b, required %b", pclk[0], clk);
    end
    @(posedge clk);
    #1;
    checks++;
    if (pclk[0] !== clk) begin
      errors++;
      $display("FAIL port_clk_high got %b, required %b", pclk[0], clk);
    end
    @(negedge clk);
    nreset = 1'b1;
  endtask

  task automatic test_zero();
    bit got;
    int nwr;
    message_addr = 32'h100;
    message_size = 32'd0;
    rle_addr     = 32'h200;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    watch(0, 2, 1'b1, 1'b0, got, nwr);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL zero_done got done=%b, required 1 within 2 cycles", done[0]);
    end
    checks++;
    if (rle_size[0] !== 32'd0) begin
      errors++;
      $display("FAIL zero_rle_size got %0d, required 0", rle_size[0]);
    end
    watch(0, 10, 1'b0, 1'b0, got, nwr);
    checks++;
    if (nwr != 0) begin
      errors++;
      $display("FAIL zero_no_write got %0d writes, required 0", nwr);
    end
  endtask

  task automatic test_basic();
    logic [7:0] b[$];
    b = '{8'h41, 8'h41, 8'h41, 8'h42};
    run_case(0, 32'h0000_0010, 32'h0000_0100, b, 1'b0, "basic");
  endtask

  task automatic test_partial();
    logic [7:0] b[$];
    for (int i = 0; i < 5; i++) b.push_back(8'h07);
    run_case(0, 32'hABCD_0041, 32'h5555_0302, b, 1'b0, "partial");
  endtask

  task automatic test_long();
    logic [7:0] b[$];
    for (int i = 0; i < 300; i++) b.push_back(8'hAA);
    run_case(0, 32'h1000, 32'h2000, b, 1'b0, "long_run");
  endtask

  task automatic test_split();
    logic [7:0] b[$];
    for (int i = 0; i < 9; i++) b.push_back(8'hAA);
    run_case(1, 32'h1000, 32'h2000, b, 1'b0, "split_max4");
  endtask

  task automatic test_alternating();
    logic [7:0] b[$];
    for (int i = 0; i < 8; i++) b.push_back((i % 2 == 0) ? 8'h01 : 8'h02);
    run_case(0, 32'h0300, 32'h0308, b, 1'b1, "alternating");
  endtask

  task automatic test_reset_mid();
    logic [7:0] b[$];
    logic [31:0] esz, ed;
    logic [15:0] ea;
    bit hit, got;
    int nwr;
    b = '{8'h41, 8'h41, 8'h41, 8'h42};
    load(0, 32'h0400, b);
    expect_writes(0, 32'h0480, b, esz);
    message_addr = 32'h0400;
    message_size = 32'd4;
    rle_addr     = 32'h0480;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      if (pwe[0]) begin
        hit = 1'b1;
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        checks++;
        if (paddr[0] !== ea || pdin[0] !== ed) begin
          errors++;
          $display("FAIL reset_mid_write got addr=%h data=%h, required addr=%h data=%h", paddr[0], pdin[0], ea, ed);
        end
        #1 nreset = 1'b0;
        #1;
        check_idle_outputs("reset_mid_outputs");
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_first_wr got no write, required one before timeout");
      nreset = 1'b0;
    end
    exp_addr.delete();
    exp_data.delete();
    watch(0, 20, 1'b0, 1'b0, got, nwr);
    checks++;
    if (nwr != 0) begin
      errors++;
      $display("FAIL reset_mid_no_write got %0d writes, required 0", nwr);
    end
    @(negedge clk);
    nreset = 1'b1;
    run_case(0, 32'h0400, 32'h0480, b, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[$];
    logic [7:0] sym;
    int len;
    for (int r = 0; r < 3; r++) begin
      b.delete();
      sym = 8'h05;
      len = $urandom_range(10, 40);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) sym = sym ^ 8'h03;
        b.push_back(sym);
      end
      run_case(1, 32'h0600 + 32'(r * 64), 32'h0A00 + 32'(r * 64), b, 1'b0, "back_to_back");
    end
  endtask

  initial begin
    nreset       = 1'b0;
    start        = 2'b00;
    message_addr = 32'd0;
    message_size = 32'd0;
    rle_addr     = 32'd0;
    ld_we        = 2'b00;
    ld_idx       = 14'd0;
    ld_data      = 32'd0;
    test_reset();
    test_zero();
    test_basic();
    test_partial();
    test_long();
    test_split();
    test_alternating();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
